// File: rtl/nr4sd_serial_encoder.sv
// nr4sd_serial_encoder
// Digit-serial radix-4 recoder for a sequential multiplier. It accepts one
// W-bit operand over a valid/ready handshake and streams its recoding
// LSB-first, one digit per cycle.
//
// Digit encodings:
//   - Non-final digits are NR4SD+ (nm, np), with value 2*np - nm in {-1,0,1,2}.
//   - The final digit is Modified-Booth (sign, one, two), with value in {-2..2}.
//   - Unsigned mode emits one extra digit, so that the final carry is absorbed
//     by a Modified-Booth digit taken over the zero-extended top bits.
//
// Ports:
//   clk, rst       clock; asynchronous active-high reset
//   in_valid       operand offered
//   in_ready       encoder can accept an operand (combinational from out_ready)
//   in_data        W-bit operand
//   in_unsigned    treat in_data as unsigned (sampled at accept)
//   out_valid      digit present on out_*
//   out_ready      consumer takes the digit
//   out_nm/out_np  NR4SD+ bits (0 on the final digit)
//   out_sign/out_one/out_two  Modified-Booth bits (0 on non-final digits)
//   out_last       current digit is the final one
//   out_idx        digit index j (weight 4^j)
module nr4sd_serial_encoder #(
   parameter int unsigned W  = 32,
   parameter int unsigned IW = $clog2(W/2+1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  in_data,
   input  logic          in_unsigned,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          out_nm,
   output logic          out_np,
   output logic          out_sign,
   output logic          out_one,
   output logic          out_two,
   output logic          out_last,
   output logic [IW-1:0] out_idx
);

   localparam int unsigned SW = W + 2;
   localparam logic [IW-1:0] LAST_IDX_S = IW'(W/2 - 1);
   localparam logic [IW-1:0] LAST_IDX_U = IW'(W/2);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [SW-1:0] sr;
   logic          c;
   logic [IW-1:0] idx;
   logic          u;

   logic run;
   logic last;
   logic accept;
   logic digit_hs;
   logic a0;
   logic a1;
   logic nr_nm;
   logic nr_np;
   logic nr_t;
   logic c_nxt;
   logic mb_b1;
   logic mb_b0;
   logic mb_sign;
   logic mb_one;
   logic mb_two;

   // Handshake and stream-position decode
   assign run      = (state == RUN);
   assign last     = run & (idx == (u ? LAST_IDX_U : LAST_IDX_S));
   assign digit_hs = run & out_ready;
   assign in_ready = ~run | (last & out_ready);
   assign accept   = in_valid & in_ready;

   // NR4SD+ digit from the low operand pair and the incoming carry
   assign a0    = sr[0];
   assign a1    = sr[1];
   assign nr_nm = a0 ^ c;
   assign nr_t  = a0 | c;
   assign nr_np = a1 ^ nr_t;
   assign c_nxt = a1 & nr_t;

   // Modified-Booth final digit; in unsigned mode the pair is the zero extension
   assign mb_b1   = sr[1] & ~u;
   assign mb_b0   = sr[0] & ~u;
   assign mb_sign = mb_b1;
   assign mb_one  = mb_b0 ^ c;
   assign mb_two  = (mb_b1 & ~mb_b0 & ~c) | (~mb_b1 & mb_b0 & c);

   // Digit outputs decode registered state only; all-zero while idle
   assign out_valid = run;
   assign out_last  = last;
   assign out_nm    = run & ~last & nr_nm;
   assign out_np    = run & ~last & nr_np;
   assign out_sign  = last & mb_sign;
   assign out_one   = last & mb_one;
   assign out_two   = last & mb_two;
   assign out_idx   = run ? idx : '0;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state; a new accept on the final handshake keeps RUN with no bubble
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (in_valid) begin
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (digit_hs && last && !in_valid) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Operand shift register, carry, digit index and mode flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr  <= '0;
         c   <= 1'b0;
         idx <= '0;
         u   <= 1'b0;
      end else if (accept) begin
         sr  <= {2'b00, in_data};
         c   <= 1'b0;
         idx <= '0;
         u   <= in_unsigned;
      end else if (digit_hs && !last) begin
         sr  <= sr >> 2;
         c   <= c_nxt;
         idx <= idx + IW'(1);
      end
   end

endmodule

// File: doc/nr4sd_serial_encoder.md
Name: nr4sd_serial_encoder

Overview:
- Parametrised, digit-serial successor to the 32-bit combinational NR4SD+ recoder.
- Accepts a W-bit operand over a valid/ready handshake, then streams its radix-4 recoding LSB-first, one digit per cycle, to a sequential multiplier datapath.
- Non-final digits use NR4SD+ encoding (nm, np), with value 2·np − nm in {−1, 0, 1, 2}. The final digit is Modified-Booth encoded (sign, one, two).
- Adds an unsigned mode that emits one extra MB digit to absorb the final carry.

Parameters:
- W, 32: operand width; must be even and ≥ 4.
- IW, $clog2(W/2+1): width of the digit index output.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operand offered.
- in_ready  out  1  encoder can accept an operand.
- in_data  in  W  operand.
- in_unsigned  in  1  1 = treat in_data as unsigned; sampled at accept.
- out_valid  out  1  digit present on the out_* ports.
- out_ready  in  1  consumer takes the digit.
- out_nm  out  1  NR4SD+ negative-weight bit; 0 on the final digit.
- out_np  out  1  NR4SD+ positive (×2) bit; 0 on the final digit.
- out_sign  out  1  MB sign; 0 on non-final digits.
- out_one  out  1  MB |d| = 1; 0 on non-final digits.
- out_two  out  1  MB |d| = 2; 0 on non-final digits.
- out_last  out  1  current digit is the final (MB) digit.
- out_idx  out  IW  index j of the current digit (weight 4^j).

Behaviour:
- State registers:
  - FSM with states IDLE and RUN.
  - Shift register sr[W+1:0].
  - Carry register c.
  - Index register idx.
  - Registered unsigned flag u.
- Reset (async, any time, including mid-stream):
  - State = IDLE; sr, c, idx, u = 0.
  - out_valid = 0, in_ready = 1, all digit outputs = 0.
  - Any in-flight operand is discarded.
- in_ready = (state == IDLE) | (state == RUN & out_last & out_ready). The out_ready → in_ready path is the only combinational input-to-output path.
- Accept occurs when in_valid & in_ready:
  - sr <= {2'b00, in_data}; c <= 0; idx <= 0; u <= in_unsigned; state <= RUN.
  - Latency: digit 0 is valid on the cycle after accept.
- Digit count:
  - Signed: N = W/2 digits, i.e. W/2 − 1 NR digits plus 1 MB digit.
  - Unsigned: N = W/2 + 1 digits, i.e. W/2 NR digits plus 1 MB digit.
  - out_last = (state == RUN) & (idx == N − 1).
- NR digit, from a0 = sr[0], a1 = sr[1], carry c:
  - out_nm = a0 ^ c; t = a0 | c.
  - out_np = a1 ^ t; c_next = a1 & t.
  - Invariant: a0 + 2·a1 + c = 2·np − nm + 4·c_next.
- MB digit, from the triple (b1, b0, c):
  - Signed: (b1, b0) = (sr[1], sr[0]), which are the operand's top two bits.
  - Unsigned: (b1, b0) = (0, 0), since sr has been zero-extended.
  - Digit value d = −2·b1 + b0 + c.
  - out_sign = b1; out_one = b0 ^ c; out_two = (b1 & ~b0 & ~c) | (~b1 & b0 & c).
  - The triple (1, 1, 1) gives sign = 1, one = 0, two = 0 (negative zero); this is permitted.
- All out_* values derive only from registered state. They are held stable while out_valid & ~out_ready (backpressure of any length).
- Handshake out_valid & out_ready:
  - Non-last digit: sr <= sr >> 2; c <= c_next; idx <= idx + 1.
  - Last digit: state <= IDLE, unless a new accept occurs in the same cycle, in which case state stays RUN with the new operand loaded (no bubble).
- in_valid while in RUN and not at the last handshake: ignored; in_ready = 0.
- Correctness: Σ d_j·4^j equals in_data, interpreted as two's complement (signed) or unsigned.

Test Plan:
- W=32, signed, in_data=0, out_ready=1 → 16 digits, all zero; out_last only at idx=15; out_valid falls the following cycle.
- W=32, signed, in_data=32'hFFFFFFFF:
  - digit 0: nm=1, np=0 (value −1).
  - idx 1..14: nm=np=0.
  - idx 15: sign=1, one=0, two=0.
  - Total value −1.
- W=32, unsigned, in_data=32'hFFFFFFFF:
  - 17 digits; digit 0 = −1; idx 1..15 = 0.
  - idx 16: sign=0, one=1, two=0, out_last=1.
  - Total 4^16 − 1.
- W=32, signed, in_data=2 → digit 0: nm=0, np=1 (value 2). Remaining digits zero, with final MB digit sign=one=two=0.
- Backpressure plus back-to-back:
  - Drop out_ready for 3 cycles at idx=5 → outputs and idx frozen.
  - Hold in_valid with in_data=7 during the last handshake → in_ready=1 that cycle; next cycle out_idx=0 shows digit 0 of 7 (nm=1, np=0), with no idle cycle.
- Assert rst at idx=8 → out_valid=0 and in_ready=1 immediately (async). After release, a new operand streams from idx=0.
- Randomised: 10^4 operands in both modes for W ∈ {4, 8, 32}; reconstruct Σ d_j·4^j and compare against in_data.
